// File: rtl/regfile_scoreboard_if.sv
// Bus between the control unit / writeback side and the register file.
// The control unit drives addresses, writeback and claims (master); the
// register file answers with read data, busy flags, claim_ok and busy_count (slave).
// Handshake: claim_en is a request held by the issuer; the claim is taken on the
// rising clock edge of any cycle where claim_ok is 1, and claim_ok is purely
// combinational from the current cycle's inputs and state. wr_en is an
// unconditional strobe with no back-pressure.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     claim_en;
   logic [ADDR_W-1:0]        claim_addr;
   logic                     claim_ok;
   logic [ADDR_W:0]          busy_count;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  rd_data, rd_busy, claim_ok, busy_count
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output rd_data, rd_busy, claim_ok, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with NUM_RD combinational read ports, one write
// port and a per-register busy scoreboard. A load issue claims its destination;
// the writeback releases it. Readers see busy so they can stall on true RAW
// hazards only. Optional XZR (top register) reads zero and is never busy.
module regfile_scoreboard #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic                 clock,
   input logic                 reset,
   regfile_scoreboard_if.slave bus
);

   localparam int                DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] XZR_ADDR  = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [ADDR_W:0]   busy_count;
   logic [ADDR_W-1:0] rd_idx [NUM_RD];

   logic wr_live;    // write that actually lands (not XZR)
   logic claim_ok;   // claim accepted this cycle
   logic claim_set;  // accepted claim that sets a busy bit
   logic count_inc;
   logic count_dec;

   function automatic logic is_xzr(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == XZR_ADDR);
   endfunction

   // Write/claim decode; a same-cycle writeback to the claimed register frees it for the claim.
   always_comb begin
      wr_live   = bus.wr_en && !is_xzr(bus.wr_addr);
      claim_ok  = bus.claim_en && (is_xzr(bus.claim_addr) || !busy[bus.claim_addr] ||
                                   (bus.wr_en && (bus.wr_addr == bus.claim_addr)));
      claim_set = claim_ok && !is_xzr(bus.claim_addr);
      // Count tracks busy bits exactly: +1 only when a clear bit gets set,
      // -1 only when a set bit gets cleared and no claim re-sets it.
      count_inc = claim_set && !busy[bus.claim_addr];
      count_dec = wr_live && busy[bus.wr_addr] &&
                  !(claim_set && (bus.claim_addr == bus.wr_addr));
   end

   // Register storage; per-entry address compare so an unknown address touches nothing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_live && (bus.wr_addr == ADDR_W'(i))) regs[i] <= bus.wr_data;
         end
      end
   end

   // Busy bits: claim beats release when both hit the same register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (claim_set && (bus.claim_addr == ADDR_W'(i))) busy[i] <= 1'b1;
            else if (wr_live && (bus.wr_addr == ADDR_W'(i))) busy[i] <= 1'b0;
         end
      end
   end

   // Number of busy registers, stepped by at most one per cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_count <= '0;
      end else if (count_inc && !count_dec) begin
         busy_count <= busy_count + COUNT_ONE;
      end else if (count_dec && !count_inc) begin
         busy_count <= busy_count - COUNT_ONE;
      end
   end

   // Split the packed read-address bus into per-port indices.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) rd_idx[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
   end

   // Read ports with write-first bypass; bypassed data is the value that releases busy.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (is_xzr(rd_idx[p])) begin
            bus.rd_data[p*DATA_W +: DATA_W] = '0;
            bus.rd_busy[p]                  = 1'b0;
         end else if (bus.wr_en && (bus.wr_addr == rd_idx[p])) begin
            bus.rd_data[p*DATA_W +: DATA_W] = bus.wr_data;
            bus.rd_busy[p]                  = 1'b0;
         end else begin
            bus.rd_data[p*DATA_W +: DATA_W] = regs[rd_idx[p]];
            bus.rd_busy[p]                  = busy[rd_idx[p]];
         end
      end
   end

   assign bus.claim_ok   = claim_ok;
   assign bus.busy_count = busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a 64x32/2-port instance with XZR and
// a 32x16/4-port instance. Expected read results are queued when addresses are
// driven and popped once the combinational outputs have settled.
module tb_regfile_scoreboard;

   logic clock;
   logic reset;

   int tests;
   int failed;

   regfile_scoreboard_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) a_if ();
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4)) b_if ();

   regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (a_if.slave)
   );

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (b_if.slave)
   );

   // Scoreboard queues for instance A
   logic [63:0] exp_q[$];
   int          port_q[$];
   logic        busy_q[$];
   // Scoreboard queues for instance B
   logic [31:0] exp_b_q[$];
   int          port_b_q[$];
   logic        busy_b_q[$];

   logic [31:0] b_model [16];

   // Clock generation
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_a();
      a_if.wr_en    = 1'b0;
      a_if.claim_en = 1'b0;
   endtask

   task automatic expect_a(input int p, input logic [4:0] addr, input logic [63:0] d, input logic b);
      a_if.rd_addr[p*5 +: 5] = addr;
      exp_q.push_back(d);
      port_q.push_back(p);
      busy_q.push_back(b);
   endtask

   task automatic drain_a(input string tag);
      #1;
      while (exp_q.size() != 0) begin
         int          p;
         logic [63:0] d;
         logic        b;
         p = port_q.pop_front();
         d = exp_q.pop_front();
         b = busy_q.pop_front();
         check({tag, "_data"}, a_if.rd_data[p*64 +: 64], d);
         check({tag, "_busy"}, 64'(a_if.rd_busy[p]), 64'(b));
      end
   endtask

   task automatic expect_b(input int p, input logic [3:0] addr, input logic [31:0] d, input logic b);
      b_if.rd_addr[p*4 +: 4] = addr;
      exp_b_q.push_back(d);
      port_b_q.push_back(p);
      busy_b_q.push_back(b);
   endtask

   task automatic drain_b(input string tag);
      #1;
      while (exp_b_q.size() != 0) begin
         int          p;
         logic [31:0] d;
         logic        b;
         p = port_b_q.pop_front();
         d = exp_b_q.pop_front();
         b = busy_b_q.pop_front();
         check({tag, "_data"}, 64'(b_if.rd_data[p*32 +: 32]), 64'(d));
         check({tag, "_busy"}, 64'(b_if.rd_busy[p]), 64'(b));
      end
   endtask

   task automatic claim_a(input logic [4:0] addr, input logic exp_ok, input string tag);
      a_if.claim_en   = 1'b1;
      a_if.claim_addr = addr;
      #1;
      check(tag, 64'(a_if.claim_ok), 64'(exp_ok));
   endtask

   task automatic write_a(input logic [4:0] addr, input logic [63:0] d);
      a_if.wr_en   = 1'b1;
      a_if.wr_addr = addr;
      a_if.wr_data = d;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      a_if.rd_addr = '0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0;
      a_if.claim_en = 1'b0; a_if.claim_addr = '0;
      b_if.rd_addr = '0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
      b_if.claim_en = 1'b0; b_if.claim_addr = '0;

      // Reset state
      repeat (2) tick();
      check("rst_cnt", 64'(a_if.busy_count), 64'd0);
      check("rst_claim_ok", 64'(a_if.claim_ok), 64'd0);
      #3 reset = 1'b0;

      // All registers read zero and idle after reset
      for (int a = 0; a < 32; a++) begin
         tick();
         expect_a(0, 5'(a), 64'd0, 1'b0);
         expect_a(1, 5'(31 - a), 64'd0, 1'b0);
         drain_a("rst_rd");
      end
      check("rst_cnt2", 64'(a_if.busy_count), 64'd0);

      // XZR ignores writes and claims
      tick();
      write_a(5'd31, 64'hDEAD);
      expect_a(0, 5'd31, 64'd0, 1'b0);
      drain_a("xzr_byp");
      tick();
      idle_a();
      expect_a(0, 5'd31, 64'd0, 1'b0);
      drain_a("xzr_rd");
      claim_a(5'd31, 1'b1, "xzr_claim_ok");
      tick();
      idle_a();
      check("xzr_cnt", 64'(a_if.busy_count), 64'd0);
      expect_a(1, 5'd31, 64'd0, 1'b0);
      drain_a("xzr_busy");

      // Write-first bypass then stored value
      write_a(5'd5, 64'h1234);
      expect_a(0, 5'd5, 64'h1234, 1'b0);
      expect_a(1, 5'd6, 64'd0, 1'b0);
      drain_a("byp5");
      tick();
      idle_a();
      expect_a(0, 5'd5, 64'h1234, 1'b0);
      expect_a(1, 5'd5, 64'h1234, 1'b0);
      drain_a("wr5");

      // Claim, refused re-claim, release by writeback
      claim_a(5'd9, 1'b1, "claim9_ok");
      tick();
      idle_a();
      expect_a(0, 5'd9, 64'd0, 1'b1);
      drain_a("busy9");
      check("cnt_after_claim9", 64'(a_if.busy_count), 64'd1);
      claim_a(5'd9, 1'b0, "reclaim9_refused");
      tick();
      idle_a();
      check("cnt_after_refuse", 64'(a_if.busy_count), 64'd1);
      write_a(5'd9, 64'hAA);
      expect_a(0, 5'd9, 64'hAA, 1'b0);
      drain_a("rel9_byp");
      tick();
      idle_a();
      check("cnt_after_rel9", 64'(a_if.busy_count), 64'd0);
      expect_a(0, 5'd9, 64'hAA, 1'b0);
      drain_a("rd9");

      // Same-cycle writeback and claim on a busy register
      claim_a(5'd3, 1'b1, "claim3_ok");
      tick();
      idle_a();
      check("cnt_claim3", 64'(a_if.busy_count), 64'd1);
      write_a(5'd3, 64'd7);
      claim_a(5'd3, 1'b1, "wr_claim3_ok");
      expect_a(0, 5'd3, 64'd7, 1'b0);
      drain_a("wr_claim3_byp");
      tick();
      idle_a();
      expect_a(0, 5'd3, 64'd7, 1'b1);
      drain_a("r3_still_busy");
      check("cnt_wr_claim3", 64'(a_if.busy_count), 64'd1);
      write_a(5'd3, 64'd8);
      tick();
      idle_a();
      check("cnt_rel3", 64'(a_if.busy_count), 64'd0);

      // Plain write to a non-busy register leaves the count alone
      write_a(5'd6, 64'h66);
      tick();
      idle_a();
      check("cnt_plain_wr", 64'(a_if.busy_count), 64'd0);
      expect_a(1, 5'd6, 64'h66, 1'b0);
      drain_a("rd6");

      // Release of one register while claiming another nets zero
      claim_a(5'd8, 1'b1, "claim8_ok");
      tick();
      idle_a();
      write_a(5'd8, 64'h88);
      claim_a(5'd7, 1'b1, "claim7_ok");
      tick();
      idle_a();
      check("cnt_swap", 64'(a_if.busy_count), 64'd1);
      expect_a(0, 5'd7, 64'd0, 1'b1);
      expect_a(1, 5'd8, 64'h88, 1'b0);
      drain_a("swap_rd");
      write_a(5'd7, 64'h77);
      tick();
      idle_a();
      check("cnt_rel7", 64'(a_if.busy_count), 64'd0);

      // Three claims, then asynchronous reset between edges
      write_a(5'd1, 64'h55);
      tick();
      idle_a();
      claim_a(5'd1, 1'b1, "claim1_ok");
      tick();
      claim_a(5'd2, 1'b1, "claim2_ok");
      tick();
      claim_a(5'd4, 1'b1, "claim4_ok");
      tick();
      idle_a();
      check("cnt_three", 64'(a_if.busy_count), 64'd3);
      expect_a(0, 5'd1, 64'h55, 1'b1);
      expect_a(1, 5'd4, 64'd0, 1'b1);
      drain_a("three_busy");
      #1 reset = 1'b1;
      #1;
      check("async_rst_cnt", 64'(a_if.busy_count), 64'd0);
      expect_a(0, 5'd1, 64'd0, 1'b0);
      expect_a(1, 5'd2, 64'd0, 1'b0);
      drain_a("async_rst_a");
      expect_a(0, 5'd4, 64'd0, 1'b0);
      expect_a(1, 5'd5, 64'd0, 1'b0);
      drain_a("async_rst_b");
      #1 reset = 1'b0;
      tick();
      claim_a(5'd1, 1'b1, "claim_after_rst");
      tick();
      idle_a();
      check("cnt_after_rst_claim", 64'(a_if.busy_count), 64'd1);

      // Four-port instance: fill r0..r14, try r15, read four addresses per cycle
      for (int i = 0; i < 16; i++) begin
         b_if.wr_en   = 1'b1;
         b_if.wr_addr = 4'(i);
         b_if.wr_data = 32'hC0DE_0000 | (32'(i) * 32'h0101 + 32'd1);
         b_model[i]   = (i == 15) ? 32'd0 : b_if.wr_data;
         tick();
      end
      b_if.wr_en = 1'b0;
      for (int k = 0; k < 16; k++) begin
         expect_b(0, 4'(k),             b_model[k],             1'b0);
         expect_b(1, 4'((k + 3)  % 16), b_model[(k + 3)  % 16], 1'b0);
         expect_b(2, 4'((k + 7)  % 16), b_model[(k + 7)  % 16], 1'b0);
         expect_b(3, 4'((k + 11) % 16), b_model[(k + 11) % 16], 1'b0);
         drain_b("b_rd");
         tick();
      end
      b_if.wr_en   = 1'b1;
      b_if.wr_addr = 4'd2;
      b_if.wr_data = 32'h1357_9BDF;
      expect_b(3, 4'd2,  32'h1357_9BDF, 1'b0);
      expect_b(0, 4'd15, 32'd0,         1'b0);
      drain_b("b_byp");
      tick();
      b_if.wr_en = 1'b0;
      check("b_cnt", 64'(b_if.busy_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the fixed 32x64, 2-read/1-write register file in the LEGv8 datapath.
- Adds a configurable read-port count and a per-register busy scoreboard.
- The scoreboard lets the datapath issue a multi-cycle memory load, keep executing independent ALU ops, and stall only on true RAW hazards.
- Sits between control unit (issue/claim) and the ALU/memory writeback bus.

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = highest register (XZR, index 2**ADDR_W-1) reads 0, ignores writes, is never busy

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = port i's register has a pending claim (consumer must stall)
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback value
claim_en  in  1  request to mark a destination busy (load issue)
claim_addr  in  ADDR_W  register to claim
claim_ok  out  1  claim accepted this cycle (combinational)
busy_count  out  ADDR_W+1  number of currently busy registers (registered)

Behaviour:
- Reset (async, active-high): all registers = 0, all busy bits = 0, busy_count = 0. Comb outputs follow: rd_data = 0, rd_busy = 0.
- Reset asserted mid-operation discards outstanding claims immediately. No ordering requirement vs. clock.
- Reads are combinational, zero latency.
- Write-first bypass: if wr_en && wr_addr == rd_addr[i] && address is not XZR, then rd_data[i] = wr_data and rd_busy[i] = 0 in that same cycle. Otherwise rd_data[i] = stored value.
- rd_busy[i] = busy[rd_addr[i]], except when the bypass above applies.
- XZR (ZERO_REG=1): rd_data = 0, rd_busy = 0, writes dropped, claims have no effect, claim_ok = claim_en.
- Write on rising clock when wr_en:
  - reg[wr_addr] <= wr_data.
  - busy[wr_addr] <= 0. Writeback always releases a claim.
  - A write to a non-busy register (plain ALU result) is legal.
- claim_ok = claim_en && (addr is XZR || !busy[claim_addr] || (wr_en && wr_addr == claim_addr)).
- Claiming an already-busy register without a same-cycle release is refused: claim_ok = 0, no state change. The issuer holds claim_en (WAW stall).
- Accepted claim on a non-XZR register sets busy[claim_addr] <= 1 on the clock edge.
- Simultaneous wr_en and accepted claim to the same address:
  - data is written;
  - busy ends at 1, because claim priority beats release;
  - busy_count is unchanged net.
- busy_count is updated registered, by -1 / 0 / +1 per cycle:
  - +1 for an accepted set on a non-busy register;
  - -1 for a release of a busy register with no same-address claim.
  - It never exceeds 2**ADDR_W-ZERO_REG and never underflows.
- No storage initialisation other than reset. X on addresses must not corrupt other entries.

Test Plan:
1. Reset, then read all ports at addr 0..31 -> rd_data = 0, rd_busy = 0, busy_count = 0. Writes to XZR (31) of 64'hDEAD -> still reads 0.
2. wr_en=1, wr_addr=5, wr_data=64'h1234 with rd_addr[0]=5 in same cycle -> rd_data[0] = 64'h1234 before the edge. Next cycle stored value is 64'h1234 on both ports.
3. Claim r9 (claim_ok=1) -> next cycle rd_busy for addr 9 = 1, busy_count = 1. Second claim of r9 -> claim_ok = 0. Then wr r9 = 64'hAA -> same cycle rd_busy = 0 with bypassed 64'hAA, next cycle busy_count = 0.
4. Busy r3, then same cycle wr_en r3 = 7 plus claim r3 -> claim_ok = 1, r3 reads 7, busy stays 1, busy_count stays 1.
5. Claim r1, r2, r4 on successive cycles -> busy_count = 3. Assert reset asynchronously between edges -> busy_count = 0, all rd_busy = 0, r1 reads 0 immediately.
6. NUM_RD=4, DATA_W=32, ADDR_W=4: write distinct values to r0..r14, read four different addresses per cycle -> each port returns its own value. r15 reads 0.
